// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: control encoding,
// opcode and flag-write constants, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    C_AND  = 4'b0000,
    C_XOR  = 4'b0001,
    C_SUB  = 4'b0010,
    C_RSB  = 4'b0011,
    C_ADD  = 4'b0100,
    C_ORR  = 4'b0101,
    C_MOV  = 4'b0110,
    C_LSL  = 4'b0111,
    C_LSR  = 4'b1000,
    C_BIC  = 4'b1001,
    C_ZERO = 4'b1010,
    C_MVN  = 4'b1100,
    C_ASR  = 4'b1101,
    C_ROR  = 4'b1110
  } alu_ctrl_e;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_NZ   = 2'b10;
  localparam logic [1:0] FLAG_NZCV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic logic is_shift(
    input alu_ctrl_e c
  );
    return c inside {C_LSL, C_LSR, C_ASR, C_ROR};
  endfunction

  function automatic logic [3:0] merge_flags(
    input logic [3:0] old_f,
    input logic [3:0] new_f,
    input logic [1:0] fw
  );
    return {fw[1] ? new_f[3:2] : old_f[3:2],
            fw[0] ? new_f[1:0] : old_f[1:0]};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {alu_op, func, sh} into datapath control,
// flag-write enables, writeback enable and the illegal-op marker.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] func,
  input  logic [1:0] sh,
  output alu_ctrl_e  ctrl,
  output logic [1:0] flag_w,
  output logic       rd_we,
  output logic       illegal
);

  logic [3:0] opc;
  logic       arith;

  assign opc = func[4:1];

  always_comb begin
    ctrl    = C_ADD;
    rd_we   = 1'b1;
    illegal = 1'b0;
    arith   = 1'b0;
    if (alu_op) begin
      unique case (1'b1)
        opc == OP_AND: ctrl = C_AND;
        opc == OP_XOR: ctrl = C_XOR;
        opc == OP_SUB: begin
          ctrl  = C_SUB;
          arith = 1'b1;
        end
        opc == OP_RSB: begin
          ctrl  = C_RSB;
          arith = 1'b1;
        end
        opc == OP_ADD: arith = 1'b1;
        opc == OP_CMP: begin
          ctrl  = C_SUB;
          arith = 1'b1;
          rd_we = 1'b0;
        end
        opc == OP_CMN: begin
          arith = 1'b1;
          rd_we = 1'b0;
        end
        opc == OP_ORR: ctrl = C_ORR;
        opc == OP_MOV && func[5]: ctrl = C_MOV;
        opc == OP_MOV && !func[5]: begin
          case (sh)
            2'd0:    ctrl = C_LSL;
            2'd1:    ctrl = C_LSR;
            2'd2:    ctrl = C_ASR;
            default: ctrl = C_ROR;
          endcase
        end
        opc == OP_BIC: ctrl = C_BIC;
        opc == OP_MVN: ctrl = C_MVN;
        default: begin
          ctrl    = C_ZERO;
          rd_we   = 1'b0;
          illegal = 1'b1;
        end
      endcase
    end
    flag_w = FLAG_NONE;
    if (alu_op && func[0] && !illegal)
      flag_w = arith ? FLAG_NZCV : FLAG_NZ;
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU: handshaked FSM, add/sub datapath,
// iterative shifter and NZCV flag register.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int SHIFT_STEP = 1,
  localparam int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alu_op,
  input  logic [5:0]         func,
  input  logic [1:0]         sh,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               rd_we,
  output logic [1:0]         flag_w,
  output logic [3:0]         flags,
  output logic               illegal
);

  localparam int M = WIDTH - 1;
  localparam int STEP_I =
    (SHIFT_STEP < WIDTH) ? SHIFT_STEP : WIDTH - 1;
  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(STEP_I);
  localparam logic [SHAMT_W:0] WFULL = (SHAMT_W+1)'(WIDTH);

  state_e       state, state_nxt;
  alu_ctrl_e    d_ctrl, ctrl_q;
  logic [1:0]   d_fw, fw_q;
  logic         d_we, d_ill, we_q;
  logic         accept, start_shift, cin;
  logic [WIDTH-1:0] opx, opy, alu_res;
  logic [WIDTH-1:0] work, shifted;
  logic [WIDTH:0]   sum;
  logic [3:0]       nzcv;
  logic [SHAMT_W-1:0] cnt, amt, cnt_nxt;
  logic [SHAMT_W:0]   ramt;

  alu_op_decode u_dec (
    .alu_op  (alu_op),
    .func    (func),
    .sh      (sh),
    .ctrl    (d_ctrl),
    .flag_w  (d_fw),
    .rd_we   (d_we),
    .illegal (d_ill)
  );

  assign in_ready    = (state == IDLE) && !flush;
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign start_shift = is_shift(d_ctrl) && (shamt != '0);

  // Subtracts run as x + ~y + 1 so the carry out is the no-borrow bit
  always_comb begin
    opx = op_a;
    opy = op_b;
    cin = 1'b0;
    if (d_ctrl == C_SUB) begin
      opy = ~op_b;
      cin = 1'b1;
    end else if (d_ctrl == C_RSB) begin
      opx = op_b;
      opy = ~op_a;
      cin = 1'b1;
    end
    sum = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    case (d_ctrl)
      C_AND:  alu_res = op_a & op_b;
      C_XOR:  alu_res = op_a ^ op_b;
      C_ORR:  alu_res = op_a | op_b;
      C_BIC:  alu_res = op_a & ~op_b;
      C_MVN:  alu_res = ~op_b;
      C_SUB, C_RSB, C_ADD: alu_res = sum[M:0];
      C_MOV, C_LSL, C_LSR, C_ASR, C_ROR: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign nzcv = {alu_res[M], alu_res == '0, sum[WIDTH],
                 (opx[M] == opy[M]) && (sum[M] != opx[M])};

  always_comb begin
    amt     = (cnt > STEP) ? STEP : cnt;
    cnt_nxt = cnt - amt;
    ramt    = WFULL - {1'b0, amt};
    case (ctrl_q)
      C_LSL:   shifted = work << amt;
      C_ASR:   shifted = $unsigned($signed(work) >>> amt);
      C_ROR:   shifted = (work >> amt) | (work << ramt);
      default: shifted = work >> amt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept) state_nxt = start_shift ? SHIFT : DONE;
      SHIFT:
        if (flush)               state_nxt = IDLE;
        else if (cnt_nxt == '0)  state_nxt = DONE;
      DONE:
        if (flush || out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= C_AND;
      work    <= '0;
      cnt     <= '0;
      fw_q    <= FLAG_NONE;
      we_q    <= 1'b0;
      result  <= '0;
      rd_we   <= 1'b0;
      flag_w  <= FLAG_NONE;
      illegal <= 1'b0;
      flags   <= '0;
    end else if (accept) begin
      ctrl_q <= d_ctrl;
      work   <= op_b;
      cnt    <= shamt;
      fw_q   <= d_fw;
      we_q   <= d_we;
      if (!start_shift) begin
        result  <= alu_res;
        rd_we   <= d_we;
        flag_w  <= d_fw;
        illegal <= d_ill;
        flags   <= merge_flags(flags, nzcv, d_fw);
      end
    end else if (state == SHIFT && !flush) begin
      work <= shifted;
      cnt  <= cnt_nxt;
      if (cnt_nxt == '0) begin
        result  <= shifted;
        rd_we   <= we_q;
        flag_w  <= fw_q;
        illegal <= 1'b0;
        flags   <= merge_flags(flags,
                     {shifted[M], shifted == '0, 2'b00}, fw_q);
      end
    end
  end

endmodule
